// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, data and memory-side signals of the shared-memory arbiter.
interface mem_port_arbiter_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              da_req;
  logic              da_we;
  logic [ADDR_W-1:0] da_addr;
  logic [DATA_W-1:0] da_wdata;
  logic              da_gnt;
  logic              da_rvalid;
  logic [DATA_W-1:0] da_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;
  modport slave(
    input  if_req, if_addr, da_req, da_we, da_addr, da_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, da_gnt, da_rvalid, da_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );
  modport master(
    output if_req, if_addr, da_req, da_we, da_addr, da_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, da_gnt, da_rvalid, da_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory between fetch (read) and data (read/write) ports,
// data-priority with a starvation counter that forces fetch through after STARVE_MAX losses.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input logic clk,
  input logic rst,
  mem_port_arbiter_if.slave p
);
  localparam int CW = $clog2(MEM_LAT + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t        state;
  logic          own_d;
  logic [CW-1:0] cnt;
  logic [SW-1:0] starve;
  logic          arb, pick_d, win;
  assign arb    = (state == IDLE) || (state == RESP);
  assign pick_d = p.da_req && !(p.if_req && starve == SW'(STARVE_MAX));
  assign win    = arb && (p.if_req || p.da_req);
  assign p.busy = state != IDLE;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      own_d       <= 1'b0;
      cnt         <= '0;
      starve      <= '0;
      p.if_gnt    <= 1'b0;
      p.da_gnt    <= 1'b0;
      p.if_rvalid <= 1'b0;
      p.da_rvalid <= 1'b0;
      p.if_rdata  <= {DATA_W{1'b0}};
      p.da_rdata  <= {DATA_W{1'b0}};
      p.mem_en    <= 1'b0;
      p.mem_we    <= 1'b0;
      p.mem_addr  <= {ADDR_W{1'b0}};
      p.mem_wdata <= {DATA_W{1'b0}};
    end else begin
      p.if_gnt    <= 1'b0;
      p.da_gnt    <= 1'b0;
      p.if_rvalid <= 1'b0;
      p.da_rvalid <= 1'b0;
      p.mem_en    <= 1'b0;
      case (state)
        IDLE, RESP: begin
          state <= win ? ISSUE : IDLE;
          if (win) begin
            own_d       <= pick_d;
            p.mem_en    <= 1'b1;
            p.mem_we    <= pick_d && p.da_we;
            p.mem_addr  <= pick_d ? p.da_addr : p.if_addr;
            p.mem_wdata <= pick_d ? p.da_wdata : {DATA_W{1'b0}};
            p.if_gnt    <= !pick_d;
            p.da_gnt    <= pick_d;
            // a contended data win implies starve < STARVE_MAX, so +1 cannot overflow
            starve      <= !pick_d ? '0 : p.if_req ? starve + SW'(1) : starve;
          end
        end
        ISSUE: begin
          state <= WAIT;
          cnt   <= CW'(MEM_LAT);
        end
        WAIT: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state       <= RESP;
            p.if_rvalid <= !own_d;
            p.da_rvalid <= own_d;
            if (!own_d) p.if_rdata <= p.mem_rdata;
            if (own_d && !p.mem_we) p.da_rdata <= p.mem_rdata;
          end
        end
      endcase
    end
  end
endmodule
